// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one carry-lookahead add/sub datapath among NREQ requesters,
// with a single valid/ready output register carrying result, flags and requester id.
module addsub_cla #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic [W-1:0] s,
  output logic         c,
  output logic         v
);
  logic [W-1:0] bx, g, p, gk, pk, gn, pn;
  logic [W:0]   cy;
  // Kogge-Stone prefix over (generate, propagate); the mode bit is the carry-in.
  always_comb begin
    bx = b ^ {W{m}};
    g  = a & bx;
    p  = a ^ bx;
    gk = g;
    pk = p;
    gn = g;
    pn = p;
    for (int d = 1; d < W; d = d * 2) begin
      gn = gk;
      pn = pk;
      for (int i = d; i < W; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i-d]);
        pn[i] = pk[i] & pk[i-d];
      end
      gk = gn;
      pk = pn;
    end
    cy = {gk | (pk & {W{m}}), m};
    s  = p ^ cy[W-1:0];
    c  = cy[W];
    v  = cy[W] ^ cy[W-1];
  end
endmodule

module addsub_arbiter #(
  parameter int W = 8,
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_m,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_s,
  output logic              res_c,
  output logic              res_v,
  output logic [IDW-1:0]    res_id
);
  logic           res_valid_q, res_valid_d, res_c_q, res_c_d, res_v_q, res_v_d;
  logic [W-1:0]   res_s_q, res_s_d;
  logic [IDW-1:0] res_id_q, res_id_d, last_q, last_d, gnt_idx;
  logic           gnt_found, slot_free, xfer, dp_m, dp_c, dp_v;
  logic [W-1:0]   dp_a, dp_b, dp_s;
  // Search downward so the candidate closest to last+1 is the one left standing.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(last_q) + k) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'((int'(last_q) + k) % NREQ);
      end
    end
    slot_free = !res_valid_q || res_ready;
    xfer      = !rst && slot_free && gnt_found;
    req_ready = xfer ? (NREQ'(1) << gnt_idx) : '0;
    dp_a      = req_a[int'(gnt_idx)*W +: W];
    dp_b      = req_b[int'(gnt_idx)*W +: W];
    dp_m      = req_m[gnt_idx];
  end
  addsub_cla #(.W(W)) u_cla (.a(dp_a), .b(dp_b), .m(dp_m), .s(dp_s), .c(dp_c), .v(dp_v));
  always_comb begin
    res_valid_d = xfer || (res_valid_q && !res_ready);
    res_s_d     = xfer ? dp_s : res_s_q;
    res_c_d     = xfer ? dp_c : res_c_q;
    res_v_d     = xfer ? dp_v : res_v_q;
    res_id_d    = xfer ? gnt_idx : res_id_q;
    last_d      = xfer ? gnt_idx : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_s_q     <= '0;
      res_c_q     <= 1'b0;
      res_v_q     <= 1'b0;
      res_id_q    <= '0;
      last_q      <= IDW'(NREQ - 1);
    end else begin
      res_valid_q <= res_valid_d;
      res_s_q     <= res_s_d;
      res_c_q     <= res_c_d;
      res_v_q     <= res_v_d;
      res_id_q    <= res_id_d;
      last_q      <= last_d;
    end
  end
  assign res_valid = res_valid_q;
  assign res_s     = res_s_q;
  assign res_c     = res_c_q;
  assign res_v     = res_v_q;
  assign res_id    = res_id_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed stimulus with literal expectations plus a per-cycle reference model compare.
module tb_addsub_arbiter;
  logic        clk, rst, res_valid, res_ready, res_c, res_v;
  logic [3:0]  req_valid, req_ready, req_m;
  logic [31:0] req_a, req_b;
  logic [7:0]  res_s, saved_s;
  logic [1:0]  res_id;
  int tests = 0, fails = 0;
  bit armed = 0;
  int m_valid, m_s, m_c, m_v, m_id, m_last;

  addsub_arbiter #(.W(8), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_m(req_m), .res_valid(res_valid),
    .res_ready(res_ready), .res_s(res_s), .res_c(res_c), .res_v(res_v), .res_id(res_id)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic m);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_m[i] = m;
    req_valid[i] = 1'b1;
  endtask

  // Reference model: arithmetic from signed/unsigned ranges, grant from a plain rotating search.
  always @(negedge clk) begin
    int g, a, b, sa, sb, r;
    bit fnd;
    logic [3:0] er;
    fnd = 0;
    g = 0;
    for (int k = 4; k >= 1; k--)
      if (req_valid[(m_last + k) % 4] === 1'b1) begin
        fnd = 1;
        g = (m_last + k) % 4;
      end
    er = (rst || (m_valid == 1 && !res_ready) || !fnd) ? 4'b0 : 4'(1 << g);
    if (armed || rst) chk("model req_ready", {28'b0, req_ready}, {28'b0, er});
    if (armed) begin
      chk("model res_valid", {31'b0, res_valid}, m_valid);
      chk("model res_s", {24'b0, res_s}, m_s);
      chk("model res_c", {31'b0, res_c}, m_c);
      chk("model res_v", {31'b0, res_v}, m_v);
      chk("model res_id", {30'b0, res_id}, m_id);
    end
    if (rst) begin
      m_valid = 0; m_s = 0; m_c = 0; m_v = 0; m_id = 0; m_last = 3;
      armed = 1;
    end else if (er != 0) begin
      a = int'(req_a[g*8 +: 8]);
      b = int'(req_b[g*8 +: 8]);
      sa = a >= 128 ? a - 256 : a;
      sb = b >= 128 ? b - 256 : b;
      if (req_m[g]) begin
        m_s = (a - b + 256) % 256;
        m_c = (a >= b) ? 1 : 0;
        r = sa - sb;
      end else begin
        m_s = (a + b) % 256;
        m_c = (a + b > 255) ? 1 : 0;
        r = sa + sb;
      end
      m_v = (r > 127 || r < -128) ? 1 : 0;
      m_valid = 1; m_id = g; m_last = g;
    end else if (m_valid == 1 && res_ready) m_valid = 0;
  end

  initial begin
    int ids[6] = '{0, 1, 2, 3, 0, 1};
    rst = 1; res_ready = 0; req_valid = 4'hF; req_a = '0; req_b = '0; req_m = '0;
    repeat (2) begin
      @(negedge clk);
      chk("reset req_ready", {28'b0, req_ready}, 32'h0);
      tick();
    end
    rst = 0; res_ready = 1;
    @(negedge clk);
    chk("reset res_valid", {31'b0, res_valid}, 32'h0);
    chk("first grant", {28'b0, req_ready}, 32'h1);
    tick();
    @(negedge clk);
    chk("first id", {30'b0, res_id}, 32'h0);
    chk("second grant", {28'b0, req_ready}, 32'h2);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("second id", {30'b0, res_id}, 32'h1);
    // add overflow
    set_req(1, 8'h7F, 8'h01, 1'b0);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("add valid", {31'b0, res_valid}, 32'h1);
    chk("add s", {24'b0, res_s}, 32'h80);
    chk("add c", {31'b0, res_c}, 32'h0);
    chk("add v", {31'b0, res_v}, 32'h1);
    chk("add id", {30'b0, res_id}, 32'h1);
    // subtracts
    set_req(2, 8'h05, 8'h07, 1'b1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("sub1 s", {24'b0, res_s}, 32'hFE);
    chk("sub1 c", {31'b0, res_c}, 32'h0);
    chk("sub1 v", {31'b0, res_v}, 32'h0);
    set_req(2, 8'h80, 8'h01, 1'b1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("sub2 s", {24'b0, res_s}, 32'h7F);
    chk("sub2 c", {31'b0, res_c}, 32'h1);
    chk("sub2 v", {31'b0, res_v}, 32'h1);
    // move the pointer to 3, then all four contend
    set_req(3, 8'h7F, 8'h7F, 1'b0);
    tick();
    set_req(0, 8'h10, 8'h20, 1'b0);
    set_req(1, 8'hFF, 8'h01, 1'b0);
    set_req(2, 8'h80, 8'h80, 1'b1);
    for (int n = 0; n < 6; n++) begin
      tick();
      if (n == 5) res_ready = 0;
      @(negedge clk);
      chk("rr id", {30'b0, res_id}, ids[n]);
      chk("rr valid", {31'b0, res_valid}, 32'h1);
    end
    chk("rr last s", {24'b0, res_s}, 32'h00);
    chk("rr last c", {31'b0, res_c}, 32'h1);
    saved_s = res_s;
    // backpressure
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("bp req_ready", {28'b0, req_ready}, 32'h0);
      chk("bp res_s", {24'b0, res_s}, {24'b0, saved_s});
      chk("bp res_id", {30'b0, res_id}, 32'h1);
    end
    tick();
    req_valid = 4'b1000; res_ready = 1;
    @(negedge clk);
    chk("bp release grant", {28'b0, req_ready}, 32'h8);
    tick();
    req_valid = '0; res_ready = 0;
    @(negedge clk);
    chk("bp release id", {30'b0, res_id}, 32'h3);
    chk("bp release s", {24'b0, res_s}, 32'hFE);
    chk("bp release v", {31'b0, res_v}, 32'h1);
    // reset while holding a result
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("midreset valid", {31'b0, res_valid}, 32'h0);
    chk("midreset s", {24'b0, res_s}, 32'h0);
    tick();
    res_ready = 1;
    set_req(2, 8'h01, 8'h02, 1'b0);
    set_req(3, 8'h03, 8'h04, 1'b1);
    @(negedge clk);
    chk("midreset grant", {28'b0, req_ready}, 32'h4);
    tick();
    req_valid = 4'b1000;
    @(negedge clk);
    chk("midreset id", {30'b0, res_id}, 32'h2);
    chk("midreset s2", {24'b0, res_s}, 32'h03);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("post id", {30'b0, res_id}, 32'h3);
    chk("post s", {24'b0, res_s}, 32'hFF);
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
